// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared size codes, state encoding and defaults for mem_access
// Purpose: access-size codes (mem_sel), FSM state encoding, default timeout,
//          and the alignment-legality check used in the IDLE detection cycle.
// Ports:   none (package).
package mem_access_pkg;

  localparam logic [3:0] SEL_BYTE = 4'b0001;
  localparam logic [3:0] SEL_HALF = 4'b0011;
  localparam logic [3:0] SEL_WORD = 4'b1111;

  localparam int DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // An unknown size code is treated as an illegal access, same as misalignment.
  function automatic logic is_bad_access(input logic [3:0] sel, input logic [1:0] lsb);
    logic bad;
    case (sel)
      SEL_BYTE: bad = 1'b0;
      SEL_HALF: bad = lsb[0];
      SEL_WORD: bad = (lsb != 2'b00);
      default:  bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - combinational byte-lane alignment and load extraction
// Purpose: maps a latched access onto the 32-bit RAM word: aligned address,
//          byte strobes, replicated store data, and extended load result.
// Ports:   i_addr/i_sel/i_is_read/i_sign_ext/i_wdata describe the access,
//          i_rdata is the RAM word; o_ram_addr, o_strobe, o_wdata, o_load_data
//          are the aligned results.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] i_addr,
  input  logic [3:0]  i_sel,
  input  logic        i_is_read,
  input  logic        i_sign_ext,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ram_addr,
  output logic [3:0]  o_strobe,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign o_ram_addr = {i_addr[31:2], 2'b00};

  always_comb begin
    o_strobe = 4'b0000;
    o_wdata  = i_wdata;
    case (i_sel)
      SEL_BYTE: begin
        o_strobe = 4'b0001 << i_addr[1:0];
        o_wdata  = {4{i_wdata[7:0]}};
      end
      SEL_HALF: begin
        o_strobe = 4'b0011 << i_addr[1:0];
        o_wdata  = {2{i_wdata[15:0]}};
      end
      default: begin
        o_strobe = 4'b1111;
        o_wdata  = i_wdata;
      end
    endcase
    // Loads never assert strobes.
    if (i_is_read) o_strobe = 4'b0000;
  end

  always_comb begin
    case (i_addr[1:0])
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_sel)
      SEL_BYTE: o_load_data = {{24{i_sign_ext & w_byte[7]}}, w_byte};
      SEL_HALF: o_load_data = {{16{i_sign_ext & w_half[15]}}, w_half};
      default:  o_load_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - load/store unit bridging the pipeline MEM stage to a RAM
// Purpose: detects load/store requests, rejects illegal ones, runs one RAM
//          access with timeout, and returns extended load data.
// Ports:   clk/rst (sync active-high); mem_* request from ID/EX and address;
//          ram_* request/response to the RAM; load_data/load_valid result;
//          stall_request, addr_error, bus_error status.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_flag,
  input  logic        mem_write_flag,
  input  logic        mem_sign_ext_flag,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_write_data,
  input  logic [31:0] address,
  output logic        ram_en,
  output logic [3:0]  ram_write_en,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_write_data,
  input  logic [31:0] ram_read_data,
  input  logic        ram_ready,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        stall_request,
  output logic        addr_error,
  output logic        bus_error
);

  // Counter value in the last ACCESS cycle allowed before abort.
  localparam logic [7:0] L_CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_addr;
  logic [3:0]  r_sel;
  logic [31:0] r_wdata;
  logic        r_sign_ext;
  logic        r_is_read;
  logic [31:0] r_load_data;
  logic        r_load_valid;
  logic        r_bus_error;

  logic        w_pending;
  logic        w_bad;
  logic        w_timeout;
  logic [31:0] w_ram_addr;
  logic [3:0]  w_strobe;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;

  assign w_pending = mem_read_flag | mem_write_flag;
  assign w_bad     = is_bad_access(mem_sel, address[1:0]);
  assign w_timeout = (r_cnt == L_CNT_LAST);

  mem_lane_align u_align (
    .i_addr      (r_addr),
    .i_sel       (r_sel),
    .i_is_read   (r_is_read),
    .i_sign_ext  (r_sign_ext),
    .i_wdata     (r_wdata),
    .i_rdata     (ram_read_data),
    .o_ram_addr  (w_ram_addr),
    .o_strobe    (w_strobe),
    .o_wdata     (w_wdata),
    .o_load_data (w_load_data)
  );

  // RAM side is quiet outside ACCESS, so a reset drops the request immediately.
  assign ram_en         = (r_state == ST_ACCESS);
  assign ram_addr       = ram_en ? w_ram_addr : 32'd0;
  assign ram_write_en   = ram_en ? w_strobe   : 4'b0000;
  assign ram_write_data = ram_en ? w_wdata    : 32'd0;
  assign load_data      = r_load_data;
  assign load_valid     = r_load_valid;
  assign bus_error      = r_bus_error;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 8'd0;
      r_addr       <= 32'd0;
      r_sel        <= 4'd0;
      r_wdata      <= 32'd0;
      r_sign_ext   <= 1'b0;
      r_is_read    <= 1'b0;
      r_load_data  <= 32'd0;
      r_load_valid <= 1'b0;
      r_bus_error  <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_load_valid <= 1'b0;
      r_bus_error  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pending && !w_bad) begin
            r_addr     <= address;
            r_sel      <= mem_sel;
            r_wdata    <= mem_write_data;
            r_sign_ext <= mem_sign_ext_flag;
            r_is_read  <= mem_read_flag;  // both flags set resolves to a read
            r_cnt      <= 8'd0;
          end
        end
        ST_ACCESS: begin
          if (ram_ready) begin
            if (r_is_read) begin
              r_load_data  <= w_load_data;
              r_load_valid <= 1'b1;
            end
          end else if (w_timeout) begin
            r_load_data  <= 32'd0;
            r_bus_error  <= 1'b1;
            r_load_valid <= r_is_read;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next_state  = r_state;
    stall_request = 1'b0;
    addr_error    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pending) begin
          if (w_bad) begin
            addr_error = 1'b1;
          end else begin
            stall_request = 1'b1;
            w_next_state  = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        stall_request = 1'b1;
        if (ram_ready || w_timeout) w_next_state = ST_DONE;
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 mem_read_flag  in  1  load request from ID/EX pipeline.
REQ-004 mem_write_flag  in  1  store request.
REQ-005 mem_sign_ext_flag  in  1  sign-extend loaded byte/half when 1, zero-extend when 0.
REQ-006 mem_sel  in  4  access size: 0001 byte, 0011 half, 1111 word.
REQ-007 mem_write_data  in  32  store source register value.
REQ-008 address  in  32  effective byte address from EX.
REQ-009 ram_en  out  1  RAM request valid.
REQ-010 ram_write_en  out  4  byte-lane write strobes; 0000 means read.
REQ-011 ram_addr  out  32  word-aligned address.
REQ-012 ram_write_data  out  32  lane-aligned store data.
REQ-013 ram_read_data  in  32  RAM read word, valid when ram_ready=1.
REQ-014 ram_ready  in  1  RAM completion strobe.
REQ-015 load_data  out  32  extracted and extended load result.
REQ-016 load_valid  out  1  one-cycle pulse; load_data valid.
REQ-017 stall_request  out  1  hold the pipeline while an access is in progress.
REQ-018 addr_error  out  1  one-cycle pulse on misaligned or illegal access.
REQ-019 bus_error  out  1  one-cycle pulse on RAM timeout.
REQ-020 Parameter TIMEOUT, default 255, meaning the maximum number of ACCESS cycles before abort.

Function
REQ-021 The block SHALL use three states: IDLE, ACCESS, DONE.
REQ-022 Access detection: in IDLE, an access is pending when (mem_read_flag | mem_write_flag) is 1.
- If both flags are 1, the access SHALL be treated as a read.
REQ-023 Misalignment conditions:
- half with address[0]=1;
- word with address[1:0]!=00;
- mem_sel not in {0001, 0011, 1111}.
On any of these, the block SHALL pulse addr_error in the detection cycle, perform no RAM access, and stay in IDLE.
REQ-024 Valid access in IDLE: the block SHALL latch the address, strobes, data and extension control, and go to ACCESS on the next edge.
REQ-025 stall_request SHALL be combinationally 1 in the IDLE detection cycle of a valid access, and in every ACCESS cycle.
- stall_request SHALL be 0 in DONE and in IDLE when no access is pending.
REQ-026 In ACCESS, ram_en=1 and the RAM outputs SHALL be driven from the latched registers and held stable until ram_ready=1.
REQ-027 ram_addr = {addr[31:2], 2'b00}.
REQ-028 Store strobes:
- byte: 0001 << addr[1:0];
- half: 0011 << addr[1:0];
- word: 1111.
Loads drive 0000.
REQ-029 Store data:
- byte: {4{wd[7:0]}};
- half: {2{wd[15:0]}};
- word: wd.
REQ-030 Load extraction:
- byte: ram_read_data[8k+7:8k], where k=addr[1:0];
- half: [15:0] if addr[1]=0, else [31:16];
- word: full 32 bits.
- Byte and half results are sign- or zero-extended per the latched extension flag.
REQ-031 When ram_ready=1 in ACCESS, the block SHALL register load_data (reads only) and go to DONE.
REQ-032 An 8-bit cycle counter SHALL clear on entry to ACCESS and increment each ACCESS cycle.
- On reaching TIMEOUT without ram_ready, the block SHALL go to DONE with bus_error=1 and load_data=0.
REQ-033 DONE SHALL last exactly one cycle:
- load_valid=1 for reads;
- bus_error holds its value from REQ-032;
- next state is IDLE.
- Flags still present in the DONE cycle SHALL NOT start a new access.
REQ-034 Minimum latency: access detected at cycle N, ram_ready at N+1, load_valid and stall_request=0 at N+2.
REQ-035 load_data SHALL hold its value until the next completed read.

Reset
REQ-036 On a clock edge with rst=1, the block SHALL set:
- state to IDLE and counter to 0;
- ram_en, ram_write_en, ram_addr, ram_write_data, load_data, load_valid, addr_error and bus_error to 0.
REQ-037 Reset during ACCESS SHALL abort the access with no load_valid, and ram_en SHALL be 0 from the cycle after the reset edge.

Structure
REQ-038 The shared bus/opcode header SHALL hold the mem_sel size codes, the state encodings and the default TIMEOUT.
REQ-039 Lane alignment and extraction (REQ-027..030) SHALL be one combinational sub-module, mem_lane_align; the FSM, counter and registers stay in mem_access.

Verification
REQ-040 LB, addr=0x1003, ram_read_data=0x80FFFFFF, sign=1, ready at N+1 -> load_data=0xFFFFFF80, load_valid at N+2.
REQ-041 SH, addr=0x2002, wd=0x0000BEEF -> ram_write_en=1100, ram_write_data=0xBEEFBEEF, ram_addr=0x2000.
REQ-042 LW, addr=0x3001 -> addr_error pulse, ram_en never 1, stall_request=0 the next cycle.
REQ-043 LBU, ram_ready withheld 255 cycles -> bus_error pulse, load_data=0, load_valid=1, return to IDLE.
REQ-044 SW, ram_ready delayed 5 cycles, rst asserted in the 3rd ACCESS cycle -> ram_en=0 the next cycle, no load_valid, all outputs 0.
